// File: rtl/sha256_pkg.sv
// Shared types, constants and bit helpers for the SHA-256 message-schedule datapath.
package sha256_pkg;

    typedef logic [31:0] word_t;

    localparam int SCHED_BUF_DEPTH = 16;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } sched_state_t;

    function automatic word_t ror32(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t shr32(input word_t x, input int unsigned n);
        return x >> n;
    endfunction

endpackage

// File: rtl/sha256_sigma.sv
// Combinational SHA-256 small sigma: SIG_SEL=0 gives sig0, SIG_SEL=1 gives sig1.
module sha256_sigma
    import sha256_pkg::*;
#(
    parameter int SIG_SEL = 0
) (
    input  word_t x_i,
    output word_t y_o
);

    localparam int unsigned ROT_A = (SIG_SEL == 0) ? 7  : 17;
    localparam int unsigned ROT_B = (SIG_SEL == 0) ? 18 : 19;
    localparam int unsigned SHF   = (SIG_SEL == 0) ? 3  : 10;

    assign y_o = ror32(x_i, ROT_A) ^ ror32(x_i, ROT_B) ^ shr32(x_i, SHF);

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, then streams W[0..NUM_ROUNDS-1]
// using a 16-entry rolling buffer where each new word overwrites W[t-16].
module sha256_msg_sched
    import sha256_pkg::*;
#(
    parameter int NUM_ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_word,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_word,
    output logic [5:0]  out_index,
    output logic        blk_done
);

    localparam logic [5:0] LAST_IDX = 6'(NUM_ROUNDS - 1);

    sched_state_t state_q, state_d;
    logic [5:0]   cnt_q, cnt_d;
    logic         blk_done_q, blk_done_d;

    word_t        sched_buf_q [SCHED_BUF_DEPTH];
    logic         wr_en;
    logic [3:0]   wr_addr;
    word_t        wr_data;

    logic [3:0]   idx_t, idx_m2, idx_m7, idx_m15;
    word_t        sig0_w, sig1_w, expanded_w;
    logic         is_expanded;
    logic         in_fire, out_fire;

    // Buffer taps; index arithmetic wraps mod 16 in 4 bits.
    assign idx_t   = cnt_q[3:0];
    assign idx_m2  = idx_t - 4'd2;
    assign idx_m7  = idx_t - 4'd7;
    assign idx_m15 = idx_t - 4'd15;

    sha256_sigma #(.SIG_SEL(0)) u_sig0 (
        .x_i (sched_buf_q[idx_m15]),
        .y_o (sig0_w)
    );

    sha256_sigma #(.SIG_SEL(1)) u_sig1 (
        .x_i (sched_buf_q[idx_m2]),
        .y_o (sig1_w)
    );

    assign expanded_w  = sig1_w + sched_buf_q[idx_m7] + sig0_w + sched_buf_q[idx_t];
    assign is_expanded = (cnt_q[5:4] != 2'b00);

    assign in_ready  = (state_q == LOAD)   && !rst;
    assign out_valid = (state_q == EXPAND) && !rst;
    assign in_fire   = in_valid  && in_ready;
    assign out_fire  = out_valid && out_ready;

    assign out_word  = is_expanded ? expanded_w : sched_buf_q[idx_t];
    assign out_index = cnt_q;
    assign blk_done  = blk_done_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        blk_done_d = 1'b0;
        wr_en      = 1'b0;
        wr_addr    = idx_t;
        wr_data    = in_word;
        case (state_q)
            LOAD: begin
                if (in_fire) begin
                    wr_en = 1'b1;
                    if (cnt_q == 6'd15) begin
                        cnt_d   = 6'd0;
                        state_d = EXPAND;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            EXPAND: begin
                if (out_fire) begin
                    wr_en   = is_expanded;
                    wr_data = expanded_w;
                    if (cnt_q == LAST_IDX) begin
                        cnt_d      = 6'd0;
                        state_d    = LOAD;
                        blk_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            cnt_q      <= 6'd0;
            blk_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            blk_done_q <= blk_done_d;
        end
    end

    // Buffer contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            sched_buf_q[wr_addr] <= wr_data;
        end
    end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: reference schedule plus hand-derived words.
module tb_sha256_msg_sched;

    localparam int NR = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] in_word = 32'h0;
    logic        in_ready, out_valid, blk_done;
    logic [31:0] out_word;
    logic [5:0]  out_index;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;

    logic [31:0] cur_blk [16];
    logic [31:0] exp_w   [NR];
    logic [31:0] hand_w  [NR];
    logic        hand_v  [NR];

    sha256_msg_sched #(.NUM_ROUNDS(NR)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_word   (in_word),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_index (out_index),
        .blk_done  (blk_done)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (blk_done) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] ref_s0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] ref_s1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    task automatic build_model();
        for (int t = 0; t < NR; t++) begin
            if (t < 16) exp_w[t] = cur_blk[t];
            else exp_w[t] = ref_s1(exp_w[t-2]) + exp_w[t-7] + ref_s0(exp_w[t-15]) + exp_w[t-16];
        end
    endtask

    task automatic set_block(input int kind);
        for (int i = 0; i < 16; i++) cur_blk[i] = 32'h0;
        for (int i = 0; i < NR; i++) begin
            hand_v[i] = 1'b0;
            hand_w[i] = 32'h0;
        end
        case (kind)
            0: for (int i = 0; i < NR; i++) hand_v[i] = 1'b1;
            1: begin
                cur_blk[0]  = 32'h61626380;
                cur_blk[15] = 32'h00000018;
                hand_v[16] = 1'b1; hand_w[16] = 32'h61626380;
                hand_v[17] = 1'b1; hand_w[17] = 32'h000F0000;
            end
            default: begin
                cur_blk[0] = 32'h00000001;
                hand_v[16] = 1'b1; hand_w[16] = 32'h00000001;
                hand_v[17] = 1'b1; hand_w[17] = 32'h00000000;
                hand_v[18] = 1'b1; hand_w[18] = 32'h0000A000;
            end
        endcase
        build_model();
    endtask

    task automatic run_block(input string nm, input int gap_pct, input int rdy_pct, input int abort_at);
        int          idx, t, guard;
        logic        stalled;
        logic [31:0] hold_w;
        logic [5:0]  hold_i;
        out_ready = 1'b0;
        idx = 0;
        guard = 0;
        while (idx < 16 && guard < 2000) begin
            @(negedge clk);
            chk({nm, ".excl"}, 32'(in_ready & out_valid), 32'h0);
            in_valid = ($urandom_range(99) >= gap_pct);
            in_word  = cur_blk[idx];
            if (in_valid && in_ready) idx++;
            guard++;
        end
        if (idx < 16) begin
            chk({nm, ".load_timeout"}, 32'(idx), 32'd16);
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
        chk({nm, ".first_vld"}, 32'(out_valid), 32'h1);
        chk({nm, ".rdy_low"}, 32'(in_ready), 32'h0);
        t = 0;
        guard = 0;
        stalled = 1'b0;
        hold_w = 32'h0;
        hold_i = 6'h0;
        while (t < NR && guard < 4000) begin
            if (stalled) begin
                chk({nm, ".hold_w"}, out_word, hold_w);
                chk({nm, ".hold_i"}, 32'(out_index), 32'(hold_i));
            end
            chk({nm, ".vld"}, 32'(out_valid), 32'h1);
            chk({nm, ".idx"}, 32'(out_index), 32'(t));
            chk({nm, ".word"}, out_word, exp_w[t]);
            if (hand_v[t]) chk({nm, ".hand"}, out_word, hand_w[t]);
            if (t == abort_at) begin
                rst = 1'b1;
                out_ready = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                #1;
                chk({nm, ".abort_rdy"}, 32'(in_ready), 32'h1);
                chk({nm, ".abort_vld"}, 32'(out_valid), 32'h0);
                chk({nm, ".abort_done"}, 32'(blk_done), 32'h0);
                return;
            end
            out_ready = ($urandom_range(99) < rdy_pct);
            stalled = !out_ready;
            hold_w = out_word;
            hold_i = out_index;
            if (out_ready) t++;
            guard++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        if (t < NR) begin
            chk({nm, ".exp_timeout"}, 32'(t), 32'(NR));
            return;
        end
        chk({nm, ".done_pulse"}, 32'(blk_done), 32'h1);
        chk({nm, ".rdy_back"}, 32'(in_ready), 32'h1);
        chk({nm, ".vld_off"}, 32'(out_valid), 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk("rst.in_ready", 32'(in_ready), 32'h0);
        chk("rst.out_valid", 32'(out_valid), 32'h0);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'h1);
        chk("post_rst.out_valid", 32'(out_valid), 32'h0);
        chk("post_rst.blk_done", 32'(blk_done), 32'h0);

        set_block(0); run_block("zero", 0, 100, -1);
        set_block(2); run_block("bit", 0, 100, -1);
        set_block(1); run_block("abc_bp", 50, 50, -1);
        #1 chk("done_cnt3", 32'(done_cnt), 32'd3);

        set_block(1); run_block("abort", 0, 100, 30);
        repeat (2) @(negedge clk);
        #1 chk("done_after_abort", 32'(done_cnt), 32'd3);
        set_block(1); run_block("reload", 0, 100, -1);
        #1 chk("done_cnt4", 32'(done_cnt), 32'd4);

        set_block(1); run_block("b2b_abc", 0, 100, -1);
        set_block(2); run_block("b2b_bit", 0, 100, -1);
        repeat (3) @(negedge clk);
        #1 chk("done_cnt6", 32'(done_cnt), 32'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
